// File: rtl/rx_word_buffer.sv
// rx_word_buffer: FIFO of parity-good 9-bit words, drops/counts bad words, locks after ERR_LIMIT consecutive bad words.
//   in : clk, rst (sync, active-high), word_in[8:0], word_ok, word_stb, rd_en, clear
//   out: rd_data[8:0], rd_valid, empty, full, count[ADDR_W:0], overflow, locked, err_count[7:0]
//   define RX_WORD_BUFFER_ERRCNT_EN to implement err_count; otherwise it is tied to zero.
module rx_word_buffer #(
  parameter int ADDR_W    = 3,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        word_in,
  input  logic              word_ok,
  input  logic              word_stb,
  input  logic              rd_en,
  input  logic              clear,
  output logic [8:0]        rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              locked,
  output logic [7:0]        err_count
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {RUN, LOCKED} state_t;
  state_t            state, state_nx;
  logic [8:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]        consec;
  logic              wr, rd, bad, good_run;
  always_comb begin
    rd       = rd_en && !empty;
    good_run = (state == RUN) && !clear && word_stb && word_ok;
    // a full FIFO still accepts when the same-cycle pop frees a slot
    wr       = good_run && (!full || rd_en);
    bad      = word_stb && !word_ok && !clear;
  end
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else     state <= state_nx;
  always_comb
    state_nx = clear ? RUN :
               (state == RUN && bad && ({1'b0, consec} + 9'd1 == 9'(ERR_LIMIT))) ? LOCKED : state;
  always_comb begin
    locked = (state == LOCKED);
    empty  = (count == '0);
    full   = (count == (ADDR_W+1)'(DEPTH));
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= word_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
      consec   <= '0;
    end else begin
      rd_valid <= rd;
      if (rd) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
      end
      if (wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (wr && !rd) count <= count + (ADDR_W+1)'(1);
      else if (rd && !wr) count <= count - (ADDR_W+1)'(1);
      if (clear) overflow <= 1'b0;
      else if (good_run && full && !rd_en) overflow <= 1'b1;
      if (clear) consec <= '0;
      else if (state == RUN && word_stb) consec <= word_ok ? 8'd0 : consec + 8'd1;
    end
  end
`ifdef RX_WORD_BUFFER_ERRCNT_EN
  always_ff @(posedge clk)
    if (rst || clear) err_count <= '0;
    else if (bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
`else
  assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_rx_word_buffer.sv
// tb_rx_word_buffer: randomized + directed check of two rx_word_buffer instances (depth 8 and 4) against a queue model.
module tb_rx_word_buffer;
  localparam int LIM = 3;
`ifdef RX_WORD_BUFFER_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, word_stb = 1'b0, word_ok = 1'b0, rd_en = 1'b0, clear = 1'b0;
  logic [8:0] word_in = '0;
  logic [8:0] a_rd_data, b_rd_data;
  logic a_rd_valid, a_empty, a_full, a_overflow, a_locked;
  logic b_rd_valid, b_empty, b_full, b_overflow, b_locked;
  logic [3:0] a_count;
  logic [2:0] b_count;
  logic [7:0] a_err_count, b_err_count;
  rx_word_buffer #(.ADDR_W(3), .ERR_LIMIT(LIM)) dut_a (
    .clk(clk), .rst(rst), .word_in(word_in), .word_ok(word_ok), .word_stb(word_stb),
    .rd_en(rd_en), .clear(clear), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .empty(a_empty), .full(a_full), .count(a_count), .overflow(a_overflow),
    .locked(a_locked), .err_count(a_err_count));
  rx_word_buffer #(.ADDR_W(2), .ERR_LIMIT(LIM)) dut_b (
    .clk(clk), .rst(rst), .word_in(word_in), .word_ok(word_ok), .word_stb(word_stb),
    .rd_en(rd_en), .clear(clear), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .empty(b_empty), .full(b_full), .count(b_count), .overflow(b_overflow),
    .locked(b_locked), .err_count(b_err_count));
  int n_cmp = 0, n_bad = 0;
  logic [8:0] mq0[$], mq1[$];
  int m_rdd[2], m_rdv[2], m_ovf[2], m_lck[2], m_err[2], m_con[2];
  int depth[2] = '{8, 4};
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step(input int k);
    logic [8:0] q[$];
    int n;
    bit r, w;
    if (k == 0) q = mq0; else q = mq1;
    if (rst) begin
      q.delete();
      m_rdd[k] = 0; m_rdv[k] = 0; m_ovf[k] = 0; m_lck[k] = 0; m_err[k] = 0; m_con[k] = 0;
    end else begin
      n = q.size();
      r = rd_en && n > 0;
      w = !clear && m_lck[k] == 0 && word_stb && word_ok && (n < depth[k] || rd_en);
      m_rdv[k] = int'(r);
      if (r) m_rdd[k] = int'(q.pop_front());
      if (w) q.push_back(word_in);
      if (clear) begin
        m_lck[k] = 0; m_con[k] = 0; m_err[k] = 0; m_ovf[k] = 0;
      end else if (word_stb) begin
        if (!word_ok && m_err[k] < 255) m_err[k]++;
        if (m_lck[k] == 0) begin
          if (word_ok) begin
            m_con[k] = 0;
            if (n == depth[k] && !rd_en) m_ovf[k] = 1;
          end else begin
            m_con[k]++;
            if (m_con[k] == LIM) m_lck[k] = 1;
          end
        end
      end
    end
    if (k == 0) mq0 = q; else mq1 = q;
  endtask
  task automatic check_all();
    chk("a.rd_valid", int'(a_rd_valid), m_rdv[0]);
    chk("a.rd_data", int'(a_rd_data), m_rdd[0]);
    chk("a.count", int'(a_count), mq0.size());
    chk("a.empty", int'(a_empty), int'(mq0.size() == 0));
    chk("a.full", int'(a_full), int'(mq0.size() == 8));
    chk("a.overflow", int'(a_overflow), m_ovf[0]);
    chk("a.locked", int'(a_locked), m_lck[0]);
    chk("a.err_count", int'(a_err_count), ERRCNT ? m_err[0] : 0);
    chk("b.rd_valid", int'(b_rd_valid), m_rdv[1]);
    chk("b.rd_data", int'(b_rd_data), m_rdd[1]);
    chk("b.count", int'(b_count), mq1.size());
    chk("b.empty", int'(b_empty), int'(mq1.size() == 0));
    chk("b.full", int'(b_full), int'(mq1.size() == 4));
    chk("b.overflow", int'(b_overflow), m_ovf[1]);
    chk("b.locked", int'(b_locked), m_lck[1]);
    chk("b.err_count", int'(b_err_count), ERRCNT ? m_err[1] : 0);
  endtask
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0; word_stb = 1'b0; word_ok = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask
  task automatic push(input logic [8:0] w, input bit ok, input bit rd);
    word_in = w; word_ok = ok; word_stb = 1'b1; rd_en = rd;
    tick();
  endtask
  task automatic pop();
    rd_en = 1'b1;
    tick();
  endtask
  initial begin
    tick();
    chk("reset.empty", int'(a_empty), 1);
    for (int i = 1; i <= 8; i++) push(9'(i), 1'b1, 1'b0);
    chk("fill.count", int'(a_count), 8);
    chk("fill.full", int'(a_full), 1);
    push(9'h1FF, 1'b1, 1'b0);
    chk("ovf.set", int'(a_overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      pop();
      chk("drain.data", int'(a_rd_data), i);
      chk("drain.valid", int'(a_rd_valid), 1);
    end
    pop();
    chk("empty_rd.valid", int'(a_rd_valid), 0);
    chk("empty_rd.data", int'(a_rd_data), 8);
    clear = 1'b1; tick();
    for (int i = 0; i < 8; i++) push(9'(16 + i), 1'b1, 1'b0);
    push(9'h0AA, 1'b1, 1'b1);
    chk("full_rw.count", int'(a_count), 8);
    chk("full_rw.ovf", int'(a_overflow), 0);
    for (int i = 0; i < 8; i++) pop();
    push(9'h101, 1'b1, 1'b0);
    push(9'h102, 1'b1, 1'b0);
    push(9'h033, 1'b0, 1'b0);
    push(9'h034, 1'b0, 1'b0);
    push(9'h103, 1'b1, 1'b0);
    push(9'h035, 1'b0, 1'b0);
    push(9'h036, 1'b0, 1'b0);
    chk("bbgbb.locked", int'(a_locked), 0);
    chk("bbgbb.err", int'(a_err_count), ERRCNT ? 4 : 0);
    push(9'h037, 1'b0, 1'b0);
    chk("lock.locked", int'(a_locked), 1);
    chk("lock.err", int'(a_err_count), ERRCNT ? 5 : 0);
    push(9'h104, 1'b1, 1'b0);
    push(9'h105, 1'b1, 1'b0);
    chk("lock.count", int'(a_count), 3);
    clear = 1'b1;
    push(9'h106, 1'b1, 1'b0);
    chk("clear.locked", int'(a_locked), 0);
    chk("clear.err", int'(a_err_count), 0);
    chk("clear.count", int'(a_count), 3);
    pop(); chk("clear.pop1", int'(a_rd_data), 9'h101);
    pop(); chk("clear.pop2", int'(a_rd_data), 9'h102);
    pop(); chk("clear.pop3", int'(a_rd_data), 9'h103);
    for (int i = 0; i < 20; i++) begin
      push(9'(9'h050 + i), 1'b1, 1'b0);
      pop();
      chk("wrap.b", int'(b_rd_data), 9'h050 + i);
    end
    for (int i = 0; i < 260; i++) push(9'h0, 1'b0, 1'b0);
    chk("sat.err", int'(a_err_count), ERRCNT ? 255 : 0);
    clear = 1'b1; tick();
    for (int i = 0; i < 5; i++) push(9'(i + 200), 1'b1, 1'b0);
    rst = 1'b1; tick();
    chk("rst.count", int'(a_count), 0);
    for (int i = 0; i < 3000; i++) begin
      word_stb = 1'($urandom_range(0, 1));
      word_ok  = $urandom_range(0, 9) != 0;
      word_in  = 9'($urandom);
      rd_en    = 1'($urandom_range(0, 1));
      clear    = $urandom_range(0, 29) == 0;
      rst      = $urandom_range(0, 299) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
